// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter: round-robin arbiter sharing one single-port memory between host (H) and core (C).
// Optional grant/conflict counters are enabled by defining TILE_MEM_ARB_PERF_EN.
module tile_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  h_req_valid,
   output logic                  h_req_ready,
   input  logic                  h_req_we,
   input  logic [ADDR_WIDTH-1:0] h_req_addr,
   input  logic [DATA_WIDTH-1:0] h_req_wdata,
   output logic                  h_rsp_valid,
   output logic [DATA_WIDTH-1:0] h_rsp_rdata,
   input  logic                  c_req_valid,
   output logic                  c_req_ready,
   input  logic                  c_req_we,
   input  logic [ADDR_WIDTH-1:0] c_req_addr,
   input  logic [DATA_WIDTH-1:0] c_req_wdata,
   output logic                  c_rsp_valid,
   output logic [DATA_WIDTH-1:0] c_rsp_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  busy,
`ifdef TILE_MEM_ARB_PERF_EN
   output logic [31:0]           h_grant_cnt,
   output logic [31:0]           c_grant_cnt,
   output logic [31:0]           conflict_cnt,
`endif
   output logic                  owner
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, owner_q, owner_d, we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, h_rdata_q, h_rdata_d, c_rdata_q, c_rdata_d;
   logic [1:0] cnt_q, cnt_d;
   logic accept, c_win, resp;
   always_comb begin
      accept = state_q == IDLE && (h_req_valid || c_req_valid);
      // on a tie the requester that did not win last time goes first
      c_win = c_req_valid && (!h_req_valid || !last_q);
      resp = state_q == RESP;
      state_d = state_q;
      last_d = last_q;
      owner_d = owner_q;
      we_d = we_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      cnt_d = cnt_q;
      h_rdata_d = (resp && !owner_q && !we_q) ? mem_dout : h_rdata_q;
      c_rdata_d = (resp && owner_q && !we_q) ? mem_dout : c_rdata_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = ISSUE;
            last_d = c_win;
            owner_d = c_win;
            we_d = c_win ? c_req_we : h_req_we;
            addr_d = c_win ? c_req_addr : h_req_addr;
            wdata_d = c_win ? c_req_wdata : h_req_wdata;
         end
         ISSUE: begin
            state_d = RD_LATENCY == 1 ? RESP : WAIT;
            cnt_d = 2'(RD_LATENCY - 1);
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            state_d = cnt_q == 2'd1 ? RESP : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         last_q <= 1'b1;
         owner_q <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         cnt_q <= '0;
         h_rdata_q <= '0;
         c_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         owner_q <= owner_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         cnt_q <= cnt_d;
         h_rdata_q <= h_rdata_d;
         c_rdata_q <= c_rdata_d;
      end
   end
   assign h_req_ready = accept && !c_win;
   assign c_req_ready = accept && c_win;
   assign mem_en = state_q == ISSUE;
   assign mem_we = mem_en && we_q;
   assign mem_addr = addr_q;
   assign mem_din = wdata_q;
   assign busy = state_q != IDLE;
   assign owner = owner_q;
   assign h_rsp_valid = resp && !owner_q;
   assign c_rsp_valid = resp && owner_q;
   assign h_rsp_rdata = h_rdata_d;
   assign c_rsp_rdata = c_rdata_d;
`ifdef TILE_MEM_ARB_PERF_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         h_grant_cnt <= '0;
         c_grant_cnt <= '0;
         conflict_cnt <= '0;
      end else begin
         h_grant_cnt <= h_grant_cnt + 32'(h_req_ready);
         c_grant_cnt <= c_grant_cnt + 32'(c_req_ready);
         conflict_cnt <= conflict_cnt + 32'(accept && h_req_valid && c_req_valid);
      end
   end
`endif
endmodule

// File: tb/tb_tile_mem_arbiter.sv
// tb_tile_mem_arbiter: directed and random checks of tile_mem_arbiter against a transaction-timeline model.
module tb_tile_mem_arbiter;
   localparam int LAT = 3;
   logic aclk = 0, aresetn = 0;
   logic h_req_valid = 0, h_req_we = 0, c_req_valid = 0, c_req_we = 0;
   logic [31:0] h_req_addr = 0, h_req_wdata = 0, c_req_addr = 0, c_req_wdata = 0;
   logic h_req_ready, h_rsp_valid, c_req_ready, c_rsp_valid, mem_en, mem_we, busy, owner;
   logic [31:0] h_rsp_rdata, c_rsp_rdata, mem_addr, mem_din, mem_dout;
`ifdef TILE_MEM_ARB_PERF_EN
   logic [31:0] h_grant_cnt, c_grant_cnt, conflict_cnt;
   logic [31:0] hg_m = 0, cg_m = 0, cf_m = 0;
`endif
   tile_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(LAT)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
      .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata), .h_rsp_valid(h_rsp_valid), .h_rsp_rdata(h_rsp_rdata),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
      .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy),
`ifdef TILE_MEM_ARB_PERF_EN
      .h_grant_cnt(h_grant_cnt), .c_grant_cnt(c_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
      .owner(owner)
   );
   always #5 aclk = ~aclk;
   // memory with LAT-cycle read pipeline; non-read slots carry garbage so late/early sampling shows up
   logic [31:0] mem [16];
   logic [31:0] pipe [LAT];
   bit filled = 0;
   always @(posedge aclk) begin
      if (!filled) begin
         for (int i = 0; i < 16; i++) mem[i] <= $urandom;
         filled <= 1;
      end else if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_din;
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[5:2]] : $urandom;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_dout = pipe[LAT-1];
   int n_cmp = 0, n_fail = 0, ncyc = 0;
   int ph = -1;
   bit cur = 0, cur_we = 0, last_m = 1, own_m = 0;
   logic [31:0] cur_addr = 0, cur_wd = 0, hrd_m = 0, crd_m = 0;
   logic [31:0] ref_mem [16];
   bit grants[$];
   int acc_t[$];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // ph counts cycles since accept: 1 = memory access, LAT+1 = response, -1 = idle
   task automatic eval(output bit acc, output bit w);
      bit both, rsp;
      logic [31:0] hx, cx;
      both = h_req_valid && c_req_valid;
      acc = ph < 0 && (h_req_valid || c_req_valid);
      w = both ? !last_m : c_req_valid;
      rsp = ph == LAT + 1;
      hx = (rsp && !cur && !cur_we) ? ref_mem[cur_addr[5:2]] : hrd_m;
      cx = (rsp && cur && !cur_we) ? ref_mem[cur_addr[5:2]] : crd_m;
      chk("h_req_ready", h_req_ready, acc && !w);
      chk("c_req_ready", c_req_ready, acc && w);
      chk("mem_en", mem_en, ph == 1);
      if (ph == 1) begin
         chk("mem_we", mem_we, cur_we);
         chk("mem_addr", mem_addr, cur_addr);
         if (cur_we) chk("mem_din", mem_din, cur_wd);
      end
      chk("busy", busy, ph >= 1);
      chk("h_rsp_valid", h_rsp_valid, rsp && !cur);
      chk("c_rsp_valid", c_rsp_valid, rsp && cur);
      chk("owner", owner, own_m);
      chk("h_rsp_rdata", h_rsp_rdata, hx);
      chk("c_rsp_rdata", c_rsp_rdata, cx);
`ifdef TILE_MEM_ARB_PERF_EN
      chk("h_grant_cnt", h_grant_cnt, hg_m);
      chk("c_grant_cnt", c_grant_cnt, cg_m);
      chk("conflict_cnt", conflict_cnt, cf_m);
`endif
      hrd_m = hx;
      crd_m = cx;
      if (acc) begin
         cur = w;
         cur_we = w ? c_req_we : h_req_we;
         cur_addr = w ? c_req_addr : h_req_addr;
         cur_wd = w ? c_req_wdata : h_req_wdata;
         last_m = w;
         own_m = w;
         ph = 1;
         grants.push_back(w);
         acc_t.push_back(ncyc);
         if (cur_we) ref_mem[cur_addr[5:2]] = cur_wd;
`ifdef TILE_MEM_ARB_PERF_EN
         if (w) cg_m++; else hg_m++;
         if (both) cf_m++;
`endif
      end else if (rsp) ph = -1;
      else if (ph >= 1) ph++;
   endtask
   task automatic cyc();
      bit a, w;
      #1 eval(a, w);
      @(posedge aclk);
      #1 ncyc++;
      if (a) begin
         if (w) c_req_valid = 0; else h_req_valid = 0;
      end
   endtask
   function automatic logic [31:0] ra();
      return {26'd0, 4'($urandom), 2'b00};
   endfunction
   task automatic req_h(input bit we, input logic [31:0] a, input logic [31:0] d);
      h_req_we = we; h_req_addr = a; h_req_wdata = d; h_req_valid = 1;
   endtask
   task automatic req_c(input bit we, input logic [31:0] a, input logic [31:0] d);
      c_req_we = we; c_req_addr = a; c_req_wdata = d; c_req_valid = 1;
   endtask
   task automatic drain();
      int k = 0;
      while ((ph >= 0 || h_req_valid || c_req_valid) && k < 50) begin
         cyc();
         k++;
      end
      chk("drain_bound", k < 50, 1);
   endtask
   initial begin
      int g0, k;
      repeat (3) @(posedge aclk);
      #1;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      chk("rst_mem_en", mem_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_h_rdata", h_rsp_rdata, 0);
      chk("rst_c_rsp_valid", c_rsp_valid, 0);
      aresetn = 1;
      cyc();
      req_h(1, 32'h40, 32'hDEADBEEF);
      repeat (LAT + 3) cyc();
      chk("hw_grant_h", grants[$], 0);
      req_c(0, 32'h40, $urandom);
      repeat (LAT + 3) cyc();
      chk("cr_grant_c", grants[$], 1);
      chk("cr_rdata_hold", c_rsp_rdata, 32'hDEADBEEF);
      g0 = grants.size();
      k = 0;
      req_h($urandom_range(0, 1), ra(), $urandom);
      req_c($urandom_range(0, 1), ra(), $urandom);
      while (grants.size() - g0 < 6 && k < 100) begin
         cyc();
         k++;
         if (grants.size() - g0 < 6) begin
            if (!h_req_valid) req_h($urandom_range(0, 1), ra(), $urandom);
            if (!c_req_valid) req_c($urandom_range(0, 1), ra(), $urandom);
         end
      end
      chk("alt_bound", k < 100, 1);
      for (int i = 0; i < 6 && g0 + i < grants.size(); i++) chk("alt_order", grants[g0+i], i % 2);
      drain();
      req_c(0, ra(), 0);
      cyc();
      cyc();
      req_h(0, ra(), 0);
      drain();
      chk("wait_order_c", grants[$-1], 1);
      chk("wait_order_h", grants[$], 0);
      chk("wait_gap", acc_t[$] - acc_t[$-1], LAT + 2);
      req_c(0, ra(), 0);
      cyc();
      cyc();
      #1 aresetn = 0;
      #1;
      chk("arst_mem_en", mem_en, 0);
      chk("arst_busy", busy, 0);
      ph = -1; last_m = 1; own_m = 0; hrd_m = 0; crd_m = 0;
`ifdef TILE_MEM_ARB_PERF_EN
      hg_m = 0; cg_m = 0; cf_m = 0;
`endif
      @(posedge aclk);
      #1 aresetn = 1;
      repeat (LAT + 2) cyc();
      req_h(0, ra(), 0);
      req_c(0, ra(), 0);
      cyc();
      chk("post_rst_grant_h", grants[$], 0);
      drain();
      g0 = grants.size();
      k = 0;
      req_c(0, ra(), 0);
      while (grants.size() - g0 < 3 && k < 50) begin
         cyc();
         k++;
         if (!c_req_valid && grants.size() - g0 < 3) req_c(0, ra(), 0);
      end
      chk("lone_bound", k < 50, 1);
      drain();
      for (int i = 1; i < 3; i++) chk("lone_gap", acc_t[g0+i] - acc_t[g0+i-1], LAT + 2);
      for (int i = 0; i < 3; i++) chk("lone_grant_c", grants[g0+i], 1);
      repeat (400) begin
         if (!h_req_valid) begin
            if ($urandom_range(0, 2) == 0) req_h($urandom_range(0, 1), ra(), $urandom);
         end else if (ph >= 0 && $urandom_range(0, 15) == 0) h_req_valid = 0;
         if (!c_req_valid) begin
            if ($urandom_range(0, 2) == 0) req_c($urandom_range(0, 1), ra(), $urandom);
         end else if (ph >= 0 && $urandom_range(0, 15) == 0) c_req_valid = 0;
         cyc();
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Shares the tile's single-port local memory between two requesters:
  - host command path: AXI-Lite CSR READ/WRITE ops, requester H;
  - RISC-V core data port: requester C.
- Sits between both requesters and the memory's mem_en/mem_we/mem_addr/mem_din/mem_dout port.
- Round-robin arbitration, one transaction in flight, fixed memory read latency.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- RD_LATENCY, 1, cycles from mem_en to valid mem_dout; legal 1..4.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- h_req_valid  in  1  host request valid
- h_req_ready  out  1  host request accepted, 1-cycle pulse
- h_req_we  in  1  1=write, 0=read
- h_req_addr  in  ADDR_WIDTH  host address
- h_req_wdata  in  DATA_WIDTH  host write data
- h_rsp_valid  out  1  host response pulse
- h_rsp_rdata  out  DATA_WIDTH  host read data
- c_req_valid, c_req_ready, c_req_we, c_req_addr, c_req_wdata, c_rsp_valid, c_rsp_rdata: same as h_*, for the core
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout  in  DATA_WIDTH  memory read data
- busy  out  1  transaction in flight
- owner  out  1  current or last grant (0=H, 1=C)

Behaviour:
- Reset: aresetn low asynchronously clears the following; all are registered.
  - FSM to IDLE.
  - All outputs 0; rsp_rdata 0.
  - last_grant=1 (C), so H wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, select a winner.
  - If only one is valid, it wins.
  - If both are valid, the one not equal to last_grant wins.
  - Assert the winner's req_ready combinationally for this cycle only.
  - Capture we/addr/wdata into internal registers; last_grant=winner; owner=winner; go to ISSUE.
  - The loser's req_ready stays 0; its request must be held stable (valid/ready handshake).
- ISSUE (1 cycle):
  - mem_en=1; mem_we=captured we; mem_addr and mem_din driven from the captured registers; busy=1.
  - Next state: if RD_LATENCY==1, RESP; else WAIT with counter=RD_LATENCY-1.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - At counter==1, go to RESP.
  - Counter width is 2 bits, with no wrap.
- RESP (1 cycle):
  - Owner's rsp_valid=1.
  - On reads, rsp_rdata=mem_dout sampled this cycle.
  - On writes, rsp_rdata holds its previous value; the pulse acts as the write ack.
  - Go to IDLE.
  - A new request can be accepted in the IDLE cycle that follows.
- Latency: accept in cycle N; mem_en in cycle N+1; rsp_valid in cycle N+1+RD_LATENCY.
- Throughput: one transaction per RD_LATENCY+2 cycles.
- busy=1 from ISSUE through RESP inclusive.
- Requests are never accepted outside IDLE.
- Simultaneous requests from the same requester are impossible (one outstanding per requester by construction).
- Fairness: a continuously requesting pair alternates H,C,H,C.
- A lone requester may win back-to-back.
- A req_valid dropped before ready is legal; nothing is issued for it.
- Reset mid-transaction: the transaction is abandoned, no rsp_valid is produced, and mem_en drops immediately.

Optional Feature:
- Macro: TILE_MEM_ARB_PERF_EN.
- When defined, adds three outputs:
  - h_grant_cnt (out, 32): grants to H.
  - c_grant_cnt (out, 32): grants to C.
  - conflict_cnt (out, 32): IDLE cycles where both req_valid are 1.
- All three reset to 0, wrap modulo 2^32, increment on the accept cycle, and are intended for tying to spare CSR count registers.
- When undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Host write: h_req addr=0x40, wdata=0xDEADBEEF, we=1, RD_LATENCY=1.
  - h_req_ready in cycle 0.
  - mem_en=1, mem_we=1, mem_addr=0x40, mem_din=0xDEADBEEF in cycle 1.
  - h_rsp_valid in cycle 2.
- Core read, RD_LATENCY=3: c_req addr=0x40 with memory model returning 0xDEADBEEF.
  - mem_en in cycle 1, mem_we=0.
  - c_rsp_valid in cycle 4 with c_rsp_rdata=0xDEADBEEF.
  - h_rsp_valid stays 0 throughout.
- Both requesters valid continuously, 6 transactions:
  - grant order H,C,H,C,H,C;
  - each rsp_valid goes to the matching requester;
  - with TILE_MEM_ARB_PERF_EN: h_grant_cnt=3, c_grant_cnt=3, conflict_cnt=6.
- H requests during C's WAIT:
  - h_req_ready stays 0 until the IDLE cycle after C's RESP;
  - H is then granted; busy never deasserts between ISSUE and RESP.
- aresetn pulsed low during WAIT of a read:
  - mem_en=0 and busy=0 immediately;
  - no rsp_valid on either port;
  - the next simultaneous request is granted to H.
- Lone core, 3 back-to-back reads:
  - c_req_ready in cycles 0, 3 and 6 (RD_LATENCY=1);
  - owner=1 throughout.
